// File: rtl/serial_mem_master.sv
// serial_mem_master: byte-serial memory command initiator.
// Serializes one write/read request into command, address and data bytes,
// then collects the responder's reply and reports read data plus status.
//
// state | meaning
// IDLE  | waiting for a request, req_rdy high
// SEND  | streaming frame bytes, one strobe per byte with a gap cycle after it
// RECV  | collecting reply bytes under the inter-byte timeout
// DONE  | resp_valid pulse with final status, then back to IDLE
module serial_mem_master #(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_rdy,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [1:0]            resp_err,
    output logic                  busy,
    output logic [7:0]            serial_data_out,
    output logic                  serial_out_en,
    input  logic                  serial_out_rdy,
    input  logic [7:0]            serial_data_in,
    input  logic                  serial_in_cplt,
    input  logic                  serial_in_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Counter is clog2(TIMEOUT_CYCLES) bits; guard against a zero-width vector.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [7:0] CMD_WRITE = 8'h00;
    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] WRITE_ACK = 8'h45;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_RX      = 2'b10;
    localparam logic [1:0] ERR_ACK     = 2'b11;

    state_t                state_q, state_nxt;
    logic                  write_q, write_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
    logic [2:0]            idx_q, idx_nxt;
    logic [2:0]            count_q, count_nxt;
    logic                  rx_idx_q, rx_idx_nxt;
    logic [CNT_W-1:0]      tmo_q, tmo_nxt;
    logic [7:0]            rdata_lo_q, rdata_lo_nxt;
    logic                  out_en_q, out_en_nxt;
    logic [7:0]            out_data_q, out_data_nxt;
    logic                  resp_valid_q, resp_valid_nxt;
    logic [1:0]            resp_err_q, resp_err_nxt;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_nxt;
    logic [7:0]            frame_byte;
    logic                  finish;
    logic [1:0]            finish_err;

    // Frame byte selected by the transmit index, multi-byte fields LSB first.
    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            3'd0:    frame_byte = write_q ? CMD_WRITE : CMD_READ;
            3'd1:    frame_byte = addr_q[7:0];
            3'd2:    frame_byte = addr_q[15:8];
            3'd3:    frame_byte = addr_q[23:16];
            3'd4:    frame_byte = wdata_q[7:0];
            3'd5:    frame_byte = wdata_q[15:8];
            default: frame_byte = 8'h00;
        endcase
    end

    // Next-state and next-register values for the whole controller.
    always_comb begin
        state_nxt      = state_q;
        write_nxt      = write_q;
        addr_nxt       = addr_q;
        wdata_nxt      = wdata_q;
        idx_nxt        = idx_q;
        count_nxt      = count_q;
        rx_idx_nxt     = rx_idx_q;
        tmo_nxt        = tmo_q;
        rdata_lo_nxt   = rdata_lo_q;
        out_en_nxt     = out_en_q;
        out_data_nxt   = out_data_q;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = resp_err_q;
        resp_rdata_nxt = resp_rdata_q;
        finish         = 1'b0;
        finish_err     = ERR_OK;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_nxt = req_write;
                    addr_nxt  = req_addr;
                    wdata_nxt = req_wdata;
                    idx_nxt   = 3'd0;
                    count_nxt = req_write ? 3'd6 : 3'd4;
                    state_nxt = S_SEND;
                end
            end

            S_SEND: begin
                if (out_en_q) begin
                    // Dropping the strobe here keeps every strobe one cycle wide.
                    out_en_nxt = 1'b0;
                    if (idx_q == count_q) begin
                        rx_idx_nxt = 1'b0;
                        tmo_nxt    = '0;
                        state_nxt  = S_RECV;
                    end
                end else if (serial_out_rdy) begin
                    out_data_nxt = frame_byte;
                    out_en_nxt   = 1'b1;
                    idx_nxt      = idx_q + 3'd1;
                end
            end

            S_RECV: begin
                if (serial_in_error) begin
                    finish     = 1'b1;
                    finish_err = ERR_RX;
                end else if (serial_in_cplt) begin
                    tmo_nxt = '0;
                    if (write_q) begin
                        finish     = 1'b1;
                        finish_err = (serial_data_in == WRITE_ACK) ? ERR_OK : ERR_ACK;
                    end else if (!rx_idx_q) begin
                        rdata_lo_nxt = serial_data_in;
                        rx_idx_nxt   = 1'b1;
                    end else begin
                        resp_rdata_nxt = {serial_data_in, rdata_lo_q};
                        finish         = 1'b1;
                        finish_err     = ERR_OK;
                    end
                end else if (tmo_q == CNT_LAST) begin
                    finish     = 1'b1;
                    finish_err = ERR_TIMEOUT;
                end else if (tmo_q != CNT_MAX) begin
                    tmo_nxt = tmo_q + 1'b1;
                end

                if (finish) begin
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = finish_err;
                    state_nxt      = S_DONE;
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            idx_q        <= 3'd0;
            count_q      <= 3'd0;
            rx_idx_q     <= 1'b0;
            tmo_q        <= '0;
            rdata_lo_q   <= 8'h00;
            out_en_q     <= 1'b0;
            out_data_q   <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_err_q   <= ERR_OK;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_nxt;
            write_q      <= write_nxt;
            addr_q       <= addr_nxt;
            wdata_q      <= wdata_nxt;
            idx_q        <= idx_nxt;
            count_q      <= count_nxt;
            rx_idx_q     <= rx_idx_nxt;
            tmo_q        <= tmo_nxt;
            rdata_lo_q   <= rdata_lo_nxt;
            out_en_q     <= out_en_nxt;
            out_data_q   <= out_data_nxt;
            resp_valid_q <= resp_valid_nxt;
            resp_err_q   <= resp_err_nxt;
            resp_rdata_q <= resp_rdata_nxt;
        end
    end

    assign req_rdy         = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign resp_valid      = resp_valid_q;
    assign resp_err        = resp_err_q;
    assign resp_rdata      = resp_rdata_q;
    assign serial_out_en   = out_en_q;
    assign serial_data_out = out_data_q;

endmodule

// File: tb/tb_serial_mem_master.sv
// Testbench for serial_mem_master: directed protocol scenarios followed by
// randomized transactions, checked against a frame/response model.
module tb_serial_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [23:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_rdy;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        busy;
    logic [7:0]  serial_data_out;
    logic        serial_out_en;
    logic        serial_out_rdy;
    logic [7:0]  serial_data_in;
    logic        serial_in_cplt;
    logic        serial_in_error;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [15:0] last_rdata = 16'h0000;

    serial_mem_master #(
        .ADDR_WIDTH(24),
        .DATA_WIDTH(16),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_rdy(req_rdy),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .busy(busy),
        .serial_data_out(serial_data_out),
        .serial_out_en(serial_out_en),
        .serial_out_rdy(serial_out_rdy),
        .serial_data_in(serial_data_in),
        .serial_in_cplt(serial_in_cplt),
        .serial_in_error(serial_in_error)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge k, cyc holds k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: normal reply, 1: no reply (timeout), 2: rx error with cplt.
    task automatic run_txn(input bit wr, input logic [23:0] a, input logic [15:0] d,
                           input bit bp, input int gap, input logic [7:0] ack, input int mode);
        logic [7:0] tx[$];
        logic [7:0] rx[$];
        logic [1:0] exp_err;
        int acc, first, last, got, hold, recv_edge, seen;
        bit prev_en, rdy_at_edge;

        tx.push_back(wr ? 8'h00 : 8'h01);
        tx.push_back(a[7:0]);
        tx.push_back(a[15:8]);
        tx.push_back(a[23:16]);
        if (wr) begin
            tx.push_back(d[7:0]);
            tx.push_back(d[15:8]);
        end

        req_valid      = 1'b1;
        req_write      = wr;
        req_addr       = a;
        req_wdata      = d;
        serial_out_rdy = 1'b1;
        tick();
        acc = cyc;
        check("accept_rdy", req_rdy, 0);
        check("accept_busy", busy, 1);
        req_valid = 1'b0;
        req_addr  = 24'($urandom);
        req_wdata = 16'($urandom);

        got = 0; hold = 0; first = 0; last = 0;
        prev_en = 1'b0; rdy_at_edge = 1'b1;
        for (int k = 0; k < 400 && got < tx.size(); k++) begin
            tick();
            if (serial_out_en) begin
                check("tx_byte", serial_data_out, tx[got]);
                check("tx_gap_low", prev_en, 0);
                check("tx_rdy_at_strobe", rdy_at_edge, 1);
                if (got == 0) first = cyc;
                last = cyc;
                got++;
                if (bp) begin
                    serial_out_rdy = 1'b0;
                    hold = 5;
                end
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) serial_out_rdy = 1'b1;
            end
            rdy_at_edge = serial_out_rdy;
            prev_en = serial_out_en;
        end
        check("tx_count", got, tx.size());
        if (!bp) begin
            check("tx_first_cycle", first, acc + 1);
            check("tx_last_cycle", last, acc + 2 * tx.size() - 1);
        end

        tick();
        check("tx_end_low", serial_out_en, 0);
        recv_edge = cyc;

        if (mode == 0) begin
            if (wr) begin
                rx.push_back(ack);
                exp_err = (ack == 8'h45) ? 2'b00 : 2'b11;
            end else begin
                rx.push_back(d[7:0]);
                rx.push_back(d[15:8]);
                exp_err = 2'b00;
            end
            for (int i = 0; i < rx.size(); i++) begin
                repeat (gap) tick();
                serial_data_in = rx[i];
                serial_in_cplt = 1'b1;
                tick();
                serial_in_cplt = 1'b0;
                serial_data_in = 8'($urandom);
                if (i < rx.size() - 1) check("rx_mid_no_resp", resp_valid, 0);
            end
            check("resp_valid", resp_valid, 1);
            check("resp_err", resp_err, exp_err);
            if (!wr) last_rdata = d;
            check("resp_rdata", resp_rdata, last_rdata);
        end else if (mode == 1) begin
            seen = 0;
            for (int k = 0; k < 200; k++) begin
                tick();
                if (resp_valid) begin
                    seen = cyc;
                    break;
                end
            end
            check("timeout_cycle", seen, recv_edge + 50);
            check("timeout_err", resp_err, 2'b01);
        end else begin
            serial_data_in  = 8'($urandom);
            serial_in_cplt  = 1'b1;
            serial_in_error = 1'b1;
            tick();
            serial_in_cplt  = 1'b0;
            serial_in_error = 1'b0;
            check("rxerr_valid", resp_valid, 1);
            check("rxerr_err", resp_err, 2'b10);
        end

        tick();
        check("resp_pulse_end", resp_valid, 0);
        check("idle_rdy", req_rdy, 1);
        check("idle_busy", busy, 0);
        check("rdata_held", resp_rdata, last_rdata);

        if (mode == 2) begin
            serial_data_in = 8'h45;
            serial_in_cplt = 1'b1;
            tick();
            serial_in_cplt = 1'b0;
            check("stray_cplt_no_resp", resp_valid, 0);
            check("stray_cplt_idle", busy, 0);
            tick();
            check("stray_cplt_no_resp2", resp_valid, 0);
        end
    endtask

    initial begin
        int got, bad;
        bit wr;
        logic [7:0] ack;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        serial_out_rdy = 1'b1; serial_data_in = 8'h00;
        serial_in_cplt = 1'b0; serial_in_error = 1'b0;
        repeat (3) tick();
        check("rst_req_rdy", req_rdy, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_out_en", serial_out_en, 0);
        check("rst_data_out", serial_data_out, 0);
        rst = 1'b0;
        tick();

        run_txn(1'b1, 24'h123456, 16'hBEEF, 1'b0, 0, 8'h45, 0);
        run_txn(1'b0, 24'h000010, 16'hABCD, 1'b0, 1, 8'h00, 0);
        run_txn(1'b1, 24'hA5C3F0, 16'h1234, 1'b1, 0, 8'h00, 0);
        run_txn(1'b0, 24'h00BEEF, 16'h0000, 1'b0, 0, 8'h00, 1);
        run_txn(1'b0, 24'h777777, 16'h0000, 1'b0, 0, 8'h00, 2);

        // Reset after the third transmitted byte of a write.
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = 24'($urandom); req_wdata = 16'($urandom);
        serial_out_rdy = 1'b1;
        tick();
        req_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 100 && got < 3; k++) begin
            tick();
            if (serial_out_en) got++;
        end
        check("rst_mid_tx_seen", got, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_rdy", req_rdy, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_en", serial_out_en, 0);
        check("rst_mid_valid", resp_valid, 0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (serial_out_en || resp_valid || busy) bad++;
        end
        check("rst_mid_quiet", bad, 0);
        run_txn(1'b0, 24'($urandom), 16'($urandom), 1'b0, 0, 8'h00, 0);

        // Randomized transactions against the model.
        for (int n = 0; n < 10; n++) begin
            wr  = 1'($urandom);
            ack = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h45;
            run_txn(wr, 24'($urandom), 16'($urandom), 1'($urandom),
                    $urandom_range(0, 4), ack, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
